// File: rtl/sa_pkg.sv
// Shared definitions for the systolic array result path: lane geometry,
// nibble count and the packed result-set type.
package sa_pkg;
  localparam int LANES = 4;
  localparam int RES_W = 8;
  localparam int OUT_W = 4;
  localparam int SET_W = LANES * RES_W;
  localparam int NIB   = SET_W / OUT_W;

  typedef logic [SET_W-1:0] result_set_t;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction
endpackage

// File: rtl/sa_result_fifo.sv
// DEPTH-entry synchronous FIFO of result sets with flush. The head entry is
// read combinationally so the serializer can present it without a bubble.
module sa_result_fifo
  import sa_pkg::*;
#(
  parameter int W     = SET_W,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int PW = clog2_min1(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // A push into a full FIFO is still taken when the head leaves this cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/sa_result_serializer.sv
// Buffers completed result sets from the array and streams them out as
// OUT_W-bit nibbles over valid/ready, lane 0 low nibble first.
module sa_result_serializer
  import sa_pkg::*;
#(
  parameter int LANES = sa_pkg::LANES,
  parameter int RES_W = sa_pkg::RES_W,
  parameter int OUT_W = sa_pkg::OUT_W,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES*RES_W-1:0] results_in,
  input  logic                   results_valid,
  input  logic                   flush,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   overflow
);
  localparam int SW    = LANES * RES_W;
  localparam int NIB_L = SW / OUT_W;
  localparam int IW    = clog2_min1(NIB_L);
  localparam int CW    = $clog2(DEPTH + 1);

  logic [SW-1:0] head;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [IW-1:0] idx_q, idx_d;
  logic          overflow_q, overflow_d;
  logic          transfer, last_idx, pop;

  sa_result_fifo #(
    .W     (SW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (results_valid),
    .pop   (pop),
    .wdata (results_in),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign last_idx = (idx_q == IW'(NIB_L - 1));
  assign transfer = !fifo_empty && out_ready;
  assign pop      = transfer && last_idx;

  assign out_valid = !fifo_empty;
  assign out_last  = out_valid && last_idx;
  assign out_data  = fifo_empty ? '0 : head[idx_q*OUT_W +: OUT_W];
  assign busy      = (fifo_count != '0);
  assign overflow  = overflow_q;

  always_comb begin
    idx_d      = idx_q;
    overflow_d = overflow_q;
    if (flush) begin
      idx_d = '0;
    end else begin
      if (transfer) idx_d = last_idx ? '0 : idx_q + IW'(1);
      // A set is lost only when nothing drains in the same cycle.
      if (results_valid && fifo_full && !pop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
    end
  end
endmodule

// File: tb/tb_sa_result_serializer.sv
// Directed and random stimulus for sa_result_serializer, checked against a
// queue-of-sets reference model every cycle.
module tb_sa_result_serializer;
  localparam int NIB   = 8;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] results_in;
  logic        results_valid;
  logic        flush;
  logic [3:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic [31:0] mq[$];
  int          pos  = 0;
  bit          movf = 1'b0;

  sa_result_serializer #(.LANES(4), .RES_W(8), .OUT_W(4), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .results_in    (results_in),
    .results_valid (results_valid),
    .flush         (flush),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .busy          (busy),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [31:0] exp_data;
    bit          exp_valid;
    exp_valid = (mq.size() > 0);
    exp_data  = exp_valid ? ((mq[0] >> (pos * 4)) & 32'hF) : 32'h0;
    chk("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
    chk("out_data",  {28'b0, out_data},  exp_data);
    chk("out_last",  {31'b0, out_last},  {31'b0, exp_valid && pos == NIB - 1});
    chk("busy",      {31'b0, busy},      {31'b0, exp_valid});
    chk("overflow",  {31'b0, overflow},  {31'b0, movf});
  endtask

  // One clock: advance the model with the inputs sampled at this edge.
  task automatic step();
    @(posedge clk);
    if (flush) begin
      mq.delete();
      pos = 0;
    end else begin
      if (mq.size() > 0 && out_ready) begin
        if (pos == NIB - 1) begin
          $display("set delivered: %08h", mq[0]);
          void'(mq.pop_front());
          pos = 0;
        end else begin
          pos++;
        end
      end
      if (results_valid) begin
        if (mq.size() < DEPTH) mq.push_back(results_in);
        else movf = 1'b1;
      end
    end
    #1 check_model();
  endtask

  task automatic cyc(input bit v, input logic [31:0] d, input bit r, input bit f);
    results_valid = v;
    results_in    = d;
    out_ready     = r;
    flush         = f;
    step();
  endtask

  task automatic async_reset();
    #1 reset = 1'b1;
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_data",  {28'b0, out_data},  32'h0);
    chk("rst_last",  {31'b0, out_last},  32'h0);
    chk("rst_busy",  {31'b0, busy},      32'h0);
    chk("rst_ovf",   {31'b0, overflow},  32'h0);
    mq.delete();
    pos  = 0;
    movf = 1'b0;
    #1 reset = 1'b0;
  endtask

  initial begin
    int          tbl[8] = '{1, 1, 2, 2, 3, 3, 4, 4};
    logic [31:0] f_set;
    reset = 1'b1;
    results_in = '0;
    results_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", {31'b0, out_valid}, 32'h0);
    chk("reset_data",  {28'b0, out_data},  32'h0);
    chk("reset_busy",  {31'b0, busy},      32'h0);
    chk("reset_ovf",   {31'b0, overflow},  32'h0);
    reset = 1'b0;

    // Single set, ready held high.
    cyc(1'b1, 32'h44332211, 1'b1, 1'b0);
    for (int i = 0; i < NIB; i++) begin
      chk("single_nib",  {28'b0, out_data}, tbl[i]);
      chk("single_last", {31'b0, out_last}, {31'b0, i == NIB - 1});
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
    end
    chk("single_busy", {31'b0, busy}, 32'h0);

    // Backpressure with ready pattern 1,0,0,1,...
    cyc(1'b1, 32'h44332211, 1'b1, 1'b0);
    for (int i = 0; i < 24; i++) cyc(1'b0, 32'h0, (i % 3) == 0, 1'b0);
    chk("bp_busy", {31'b0, busy}, 32'h0);

    // Overflow: three sets under full backpressure.
    cyc(1'b1, 32'hA1A2A3A4, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 32'hB1B2B3B4, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 32'hC1C2C3C4, 1'b0, 1'b0);
    chk("ovf_set", {31'b0, overflow}, 32'h1);
    for (int i = 0; i < 18; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("ovf_drained", {31'b0, busy}, 32'h0);

    // Async reset mid-stream, then restart at nibble 0.
    cyc(1'b1, 32'h9ABCDEF0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    async_reset();
    cyc(1'b1, 32'h13579BDF, 1'b1, 1'b0);
    chk("rst_restart", {28'b0, out_data}, 32'hF);
    for (int i = 0; i < NIB; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Full FIFO with a push on the cycle the head's last nibble leaves.
    cyc(1'b1, 32'hAAAA5555, 1'b0, 1'b0);
    cyc(1'b1, 32'hBBBB6666, 1'b0, 1'b0);
    for (int i = 0; i < NIB - 1; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, 32'hDDDD7777, 1'b1, 1'b0);
    chk("fullpop_ovf", {31'b0, overflow}, 32'h0);
    chk("fullpop_b",   {28'b0, out_data}, 32'h6);
    for (int i = 0; i < 2 * NIB; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush after three nibbles; a pulse alongside the flush is discarded.
    cyc(1'b1, 32'h11223344, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, 32'hEEEEEEEE, 1'b1, 1'b1);
    chk("flush_valid", {31'b0, out_valid}, 32'h0);
    f_set = 32'h55667788;
    cyc(1'b1, f_set, 1'b1, 1'b0);
    chk("flush_restart", {28'b0, out_data}, {28'b0, f_set[3:0]});
    for (int i = 0; i < NIB; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 5) == 0), $urandom, ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 60) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sa_result_serializer.md
# sa_result_serializer

Downstream stage of the 4x4 systolic array. Captures each completed result set (four 8-bit lane results, qualified by the array's one-cycle `valid_out` pulse) into a small FIFO and streams it out as 4-bit nibbles over a valid/ready handshake. It lets the array's wide result bus leave the chip through the same 4-bit pin budget used for `data_in`. Drops and flags result sets that arrive when the buffer is full.

## Interface
Parameters:
- `LANES`, 4, result lanes per set.
- `RES_W`, 8, bits per lane result.
- `OUT_W`, 4, output nibble width; `LANES*RES_W` must be a multiple of `OUT_W`.
- `DEPTH`, 2, result sets buffered (≥1).

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `results_in`  in  LANES*RES_W  lane k at bits [k*RES_W +: RES_W].
- `results_valid`  in  1  one-cycle pulse, sampled with `results_in`.
- `flush`  in  1  synchronous discard of all buffered data.
- `out_data`  out  OUT_W  current nibble.
- `out_valid`  out  1  `out_data` holds a valid nibble.
- `out_ready`  in  1  consumer accepts the nibble this cycle.
- `out_last`  out  1  current nibble is the final one of its set.
- `busy`  out  1  FIFO non-empty.
- `overflow`  out  1  sticky: a result set was dropped.

## Operation
- NIB = LANES*RES_W/OUT_W (8 by default). Nibble order: lane 0 first, low nibble first within lane; nibble i = head[i*OUT_W +: OUT_W].
- FIFO: DEPTH entries, write ptr, read ptr, occupancy count 0..DEPTH, ptrs wrap modulo DEPTH.
- Write: `results_valid` and (not full, or a pop in the same cycle) → entry stored. Full with no pop → set dropped, `overflow` <= 1.
- Output: `out_valid` = not empty. `out_data` = nibble `idx` of head entry; 0 when empty.
- Transfer = `out_valid && out_ready`. On transfer: idx < NIB-1 → idx+1; idx == NIB-1 → idx <= 0 and head popped.
- `out_last` = `out_valid && idx == NIB-1`.
- Write into an empty FIFO while popping is impossible (no pop when empty); write and pop at count 1 leave count 1 and present the new set at idx 0 next cycle.
- `out_valid` and `out_data` stay stable while `out_ready` is low (no retraction).
- `flush`: count, ptrs, idx <= 0; a `results_valid` in the same cycle is discarded; `overflow` is not cleared.
- `overflow` clears only on `reset`.
- `busy` = count != 0.
- Reset (async): count, ptrs, idx, `overflow` = 0; hence `out_valid`, `out_last`, `busy`, `out_data` = 0. Reset mid-stream abandons any partial set. The first set after reset starts at nibble 0.

## Timing
- Latency: `results_valid` in cycle N → `out_valid`=1 with nibble 0 in cycle N+1.
- Throughput: one nibble per cycle with `out_ready` held high; NIB cycles per set, back-to-back with no gap between sets.
- Array output rate (≤1 set per ~11+ cycles) is below the drain rate at full `out_ready`, so overflow only occurs under backpressure.
- All outputs are registered-state-derived (combinational from count/idx/FIFO RAM). There is no combinational path from `out_ready` to `out_valid`/`out_data`.

## Structure
- Shared package `sa_pkg`: `LANES`, `RES_W`, `OUT_W`, derived `NIB`, typedef `result_set_t` (LANES*RES_W packed). It is reused by the array's top-level wrapper.
- Sub-module `sa_result_fifo`: DEPTH-entry synchronous FIFO of `result_set_t` with push/pop/full/empty/count and flush.
- Nibble counter, mux and overflow flag live in `sa_result_serializer`.

## Test plan
- Single set: results_in = {8'h44,8'h33,8'h22,8'h11} (lane 3..0) pulse, `out_ready`=1 → cycles N+1..N+8 out_data = 1,1,2,2,3,3,4,4. `out_last` only on the 8th; then `busy`=0.
- Backpressure: same set, `out_ready` toggled 1,0,0,1,... → each nibble held stable while low. The exact 8-nibble sequence is delivered with no duplicates.
- Overflow: `out_ready`=0, three pulses (sets A,B,C) → `overflow`=1 after C. Releasing ready yields A then B (16 nibbles), and C never appears.
- Full with simultaneous pop: DEPTH=2 full, `results_valid` in the cycle of A's last-nibble transfer → set accepted, `overflow` stays 0. Output is B then the new set.
- Flush/reset mid-stream: assert `flush` after 3 nibbles → `out_valid`=0 next cycle. A new pulse restarts at nibble 0. Repeat with async `reset` pulse between clock edges → all outputs 0 immediately, `overflow` cleared.
